// File: rtl/bp_be_pkg.sv
// Shared types for the back-end thread controller: per-thread run state,
// scheduler CSR selects and scheduler mode encodings.
package bp_be_pkg;

   typedef enum logic [1:0] {
      e_thr_disabled,
      e_thr_run,
      e_thr_wait,
      e_thr_wake
   } bp_be_thread_state_e;

   typedef enum logic [1:0] {
      e_sel_enable,
      e_sel_mode,
      e_sel_override,
      e_sel_priority
   } bp_be_sched_csr_sel_e;

   localparam logic [7:0] sched_mode_rr   = 8'h00;
   localparam logic [7:0] sched_mode_sw   = 8'h01;
   localparam logic [7:0] sched_mode_prio = 8'h02;

endpackage

// File: rtl/bp_be_thread_monitor.sv
// One thread's run state: holds the mwait monitor address and timeout counter
// and decides when a waiting thread is woken.
module bp_be_thread_monitor
   import bp_be_pkg::*;
#(
   parameter int paddr_width_p   = 40,
   parameter int timeout_width_p = 16,
   parameter bit reset_run_p     = 1'b0
)(
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       en_set_i,
   input  logic                       en_clr_i,
   input  logic                       mwait_acc_i,
   input  logic [paddr_width_p-1:0]   mwait_addr_i,
   input  logic [timeout_width_p-1:0] mwait_timeout_i,
   input  logic                       store_v_i,
   input  logic [paddr_width_p-1:0]   store_addr_i,
   output bp_be_thread_state_e        state_o
);

   bp_be_thread_state_e          r_state;
   logic [paddr_width_p-1:0]     r_addr;
   logic [timeout_width_p-1:0]   r_cnt;
   logic                         w_hit;
   logic                         w_expire;

   // Match on the 8-byte granule: the low three address bits are shifted out.
   assign w_hit    = store_v_i && (((store_addr_i ^ r_addr) >> 3) == '0);
   assign w_expire = (r_cnt == timeout_width_p'(1));
   assign state_o  = r_state;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state <= reset_run_p ? e_thr_run : e_thr_disabled;
         r_addr  <= '0;
         r_cnt   <= '0;
      end else if (en_clr_i) begin
         r_state <= e_thr_disabled;
      end else begin
         case (r_state)
            e_thr_disabled: if (en_set_i) r_state <= e_thr_run;
            e_thr_run: if (mwait_acc_i) begin
               r_state <= e_thr_wait;
               r_addr  <= mwait_addr_i;
               r_cnt   <= mwait_timeout_i;
            end
            e_thr_wait: begin
               if (w_hit || w_expire) r_state <= e_thr_wake;
               if (r_cnt != '0) r_cnt <= r_cnt - timeout_width_p'(1);
            end
            default: r_state <= e_thr_run;
         endcase
      end
   end

endmodule

// File: rtl/bp_be_thread_ctrl_mt.sv
// Scheduler-side thread control: CSR registers, mwait acceptance, and one
// run-state monitor per hardware thread.
module bp_be_thread_ctrl_mt
   import bp_be_pkg::*;
#(
   parameter int         num_threads_gp     = 4,
   parameter int         thread_id_width_p  = 2,
   parameter int         paddr_width_p      = 40,
   parameter int         timeout_width_p    = 16,
   parameter logic [7:0] default_priority_p = 8'h80
)(
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 csr_w_v_i,
   input  logic [1:0]                           csr_w_sel_i,
   input  logic [thread_id_width_p-1:0]         csr_w_tid_i,
   input  logic [63:0]                          csr_w_data_i,
   input  logic [thread_id_width_p-1:0]         active_tid_i,
   input  logic                                 mwait_v_i,
   input  logic [thread_id_width_p-1:0]         mwait_tid_i,
   input  logic [paddr_width_p-1:0]             mwait_addr_i,
   input  logic [timeout_width_p-1:0]           mwait_timeout_i,
   output logic                                 mwait_ready_o,
   input  logic                                 store_v_i,
   input  logic [paddr_width_p-1:0]             store_addr_i,
   output logic [num_threads_gp-1:0]            thread_enabled_o,
   output logic [num_threads_gp-1:0]            thread_blocked_o,
   output logic [num_threads_gp-1:0][7:0]       thread_priority_o,
   output logic [7:0]                           scheduler_mode_o,
   output logic [thread_id_width_p-1:0]         scheduler_override_tid_o,
   output logic [num_threads_gp-1:0]            wake_mask_o
);

   localparam logic [63:0] lp_num_threads = 64'(num_threads_gp);

   bp_be_sched_csr_sel_e                 w_sel;
   logic [num_threads_gp-1:0]            w_run, w_mask, w_set, w_clr;
   logic                                 w_en_wr, w_acc;
   logic [7:0]                           r_mode;
   logic [thread_id_width_p-1:0]         r_override;
   logic [num_threads_gp-1:0][7:0]       r_prio;

   assign w_sel   = bp_be_sched_csr_sel_e'(csr_w_sel_i);
   assign w_en_wr = csr_w_v_i && (w_sel == e_sel_enable);
   // Thread 0 is kept alive if software writes an empty mask.
   assign w_mask  = (csr_w_data_i[num_threads_gp-1:0] == '0) ? num_threads_gp'(1)
                                                             : csr_w_data_i[num_threads_gp-1:0];
   assign w_set   = {num_threads_gp{w_en_wr}} &  w_mask;
   assign w_clr   = {num_threads_gp{w_en_wr}} & ~w_mask;

   always_comb begin
      mwait_ready_o = 1'b0;
      for (int t = 0; t < num_threads_gp; t++)
         if ((active_tid_i == thread_id_width_p'(t)) && w_run[t]) mwait_ready_o = 1'b1;
   end

   assign w_acc = mwait_v_i && mwait_ready_o && (mwait_tid_i == active_tid_i);

   for (genvar t = 0; t < num_threads_gp; t++) begin : g_thr
      bp_be_thread_state_e w_state;

      bp_be_thread_monitor #(
         .paddr_width_p   (paddr_width_p),
         .timeout_width_p (timeout_width_p),
         .reset_run_p     (t == 0)
      ) u_mon (
         .clk_i           (clk_i),
         .reset_i         (reset_i),
         .en_set_i        (w_set[t]),
         .en_clr_i        (w_clr[t]),
         .mwait_acc_i     (w_acc && (mwait_tid_i == thread_id_width_p'(t))),
         .mwait_addr_i    (mwait_addr_i),
         .mwait_timeout_i (mwait_timeout_i),
         .store_v_i       (store_v_i),
         .store_addr_i    (store_addr_i),
         .state_o         (w_state)
      );

      assign w_run[t]            = (w_state == e_thr_run);
      assign thread_enabled_o[t] = (w_state != e_thr_disabled);
      assign thread_blocked_o[t] = (w_state == e_thr_wait);
      assign wake_mask_o[t]      = (w_state == e_thr_wake);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_mode     <= '0;
         r_override <= '0;
         r_prio     <= {num_threads_gp{default_priority_p}};
      end else if (csr_w_v_i) begin
         case (w_sel)
            e_sel_mode: r_mode <= csr_w_data_i[7:0];
            // Out-of-range thread ids would steer the scheduler to a nonexistent thread.
            e_sel_override: if (csr_w_data_i < lp_num_threads)
               r_override <= csr_w_data_i[thread_id_width_p-1:0];
            e_sel_priority:
               for (int t = 0; t < num_threads_gp; t++)
                  if (csr_w_tid_i == thread_id_width_p'(t)) r_prio[t] <= csr_w_data_i[7:0];
            default: ;
         endcase
      end
   end

   assign thread_priority_o        = r_prio;
   assign scheduler_mode_o         = r_mode;
   assign scheduler_override_tid_o = r_override;

endmodule

// File: tb/tb_bp_be_thread_ctrl_mt.sv
// Scoreboard bench for the thread controller: each stimulus row pushes the
// expected {ready, enabled, blocked, wake} seen one edge later.
module tb_bp_be_thread_ctrl_mt;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        csr_w_v_i;
   logic [1:0]  csr_w_sel_i;
   logic [1:0]  csr_w_tid_i;
   logic [63:0] csr_w_data_i;
   logic [1:0]  active_tid_i;
   logic        mwait_v_i;
   logic [1:0]  mwait_tid_i;
   logic [39:0] mwait_addr_i;
   logic [15:0] mwait_timeout_i;
   logic        mwait_ready_o;
   logic        store_v_i;
   logic [39:0] store_addr_i;
   logic [3:0]  thread_enabled_o, thread_blocked_o, wake_mask_o;
   logic [3:0][7:0] thread_priority_o;
   logic [7:0]  scheduler_mode_o;
   logic [1:0]  scheduler_override_tid_o;

   bp_be_thread_ctrl_mt dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .csr_w_v_i(csr_w_v_i), .csr_w_sel_i(csr_w_sel_i), .csr_w_tid_i(csr_w_tid_i),
      .csr_w_data_i(csr_w_data_i), .active_tid_i(active_tid_i),
      .mwait_v_i(mwait_v_i), .mwait_tid_i(mwait_tid_i), .mwait_addr_i(mwait_addr_i),
      .mwait_timeout_i(mwait_timeout_i), .mwait_ready_o(mwait_ready_o),
      .store_v_i(store_v_i), .store_addr_i(store_addr_i),
      .thread_enabled_o(thread_enabled_o), .thread_blocked_o(thread_blocked_o),
      .thread_priority_o(thread_priority_o), .scheduler_mode_o(scheduler_mode_o),
      .scheduler_override_tid_o(scheduler_override_tid_o), .wake_mask_o(wake_mask_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [39:0] A = 40'h00_8000_0040;

   typedef struct {
      logic        mwv;
      logic [1:0]  mtid, act;
      logic [15:0] to;
      logic        stv;
      logic [39:0] sa;
      logic        cv;
      logic [1:0]  sel;
      logic [63:0] d;
      logic [12:0] exp;
   } row_t;

   logic [12:0] sb[$];
   logic [12:0] got, want;
   int n_vec = 0;
   int n_err = 0;

   function automatic logic [12:0] e(logic rdy, logic [3:0] en, logic [3:0] blk, logic [3:0] wk);
      return {rdy, en, blk, wk};
   endfunction

   function automatic row_t mk(logic mwv, logic [1:0] mtid, logic [1:0] act, logic [15:0] to,
                               logic stv, logic [39:0] sa, logic cv, logic [1:0] sel,
                               logic [63:0] d, logic [12:0] exp);
      row_t r;
      r.mwv = mwv; r.mtid = mtid; r.act = act; r.to = to; r.stv = stv; r.sa = sa;
      r.cv = cv; r.sel = sel; r.d = d; r.exp = exp;
      return r;
   endfunction

   function automatic row_t idle(logic [1:0] act, logic [12:0] exp);
      return mk(1'b0, 2'd0, act, 16'd0, 1'b0, 40'd0, 1'b0, 2'd0, 64'd0, exp);
   endfunction

   function automatic row_t mw(logic [1:0] tid, logic [1:0] act, logic [15:0] to, logic [12:0] exp);
      return mk(1'b1, tid, act, to, 1'b0, 40'd0, 1'b0, 2'd0, 64'd0, exp);
   endfunction

   function automatic row_t st(logic [1:0] act, logic [39:0] sa, logic [12:0] exp);
      return mk(1'b0, 2'd0, act, 16'd0, 1'b1, sa, 1'b0, 2'd0, 64'd0, exp);
   endfunction

   task automatic drive(input row_t r);
      mwait_v_i = r.mwv; mwait_tid_i = r.mtid; active_tid_i = r.act;
      mwait_addr_i = A; mwait_timeout_i = r.to;
      store_v_i = r.stv; store_addr_i = r.sa;
      csr_w_v_i = r.cv; csr_w_sel_i = r.sel; csr_w_tid_i = 2'd0; csr_w_data_i = r.d;
      sb.push_back(r.exp);
   endtask

   task automatic test_reset();
      drive(idle(2'd0, 13'd0));
      void'(sb.pop_front());
      reset_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
      n_vec++;
      if (got !== e(1'b1, 4'b0001, 4'b0, 4'b0)) begin
         n_err++; $display("FAIL reset_state got=%b want=%b", got, e(1'b1, 4'b0001, 4'b0, 4'b0));
      end
      n_vec++;
      if ({scheduler_mode_o, scheduler_override_tid_o} !== 10'd0) begin
         n_err++; $display("FAIL reset_mode_ovr got=%h/%h want=0/0", scheduler_mode_o, scheduler_override_tid_o);
      end
      for (int t = 0; t < 4; t++) begin
         n_vec++;
         if (thread_priority_o[t] !== 8'h80) begin
            n_err++; $display("FAIL reset_prio[%0d] got=%h want=80", t, thread_priority_o[t]);
         end
      end
      reset_i = 1'b1;
   endtask

   task automatic test_enable();
      row_t rows[$];
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 64'h6, e(0, 4'b0110, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 64'h0, e(1, 4'b0001, 0, 0)));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 64'h7, e(1, 4'b0111, 0, 0)));
      rows.push_back(idle(2'd0, e(1, 4'b0111, 0, 0)));
      foreach (rows[i]) begin
         drive(rows[i]); @(posedge clk_i); #1;
         got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
         want = sb.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL enable[%0d] got=%b want=%b", i, got, want); end
      end
   endtask

   task automatic test_csr();
      logic [1:0]  sels[5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd1};
      logic [63:0] ds[5]   = '{64'h102, 64'h33, 64'h3, 64'h7, 64'hA5};
      logic [17:0] ex[5]   = '{{8'h02, 2'd0, 8'h80}, {8'h02, 2'd0, 8'h33}, {8'h02, 2'd3, 8'h33},
                               {8'h02, 2'd3, 8'h33}, {8'hA5, 2'd3, 8'h33}};
      logic [17:0] q[$];
      logic [17:0] g, w;
      for (int i = 0; i < 5; i++) begin
         drive(idle(2'd0, 13'd0)); void'(sb.pop_front());
         csr_w_v_i = 1'b1; csr_w_sel_i = sels[i]; csr_w_tid_i = 2'd2; csr_w_data_i = ds[i];
         q.push_back(ex[i]);
         @(posedge clk_i); #1;
         g = {scheduler_mode_o, scheduler_override_tid_o, thread_priority_o[2]};
         w = q.pop_front(); n_vec++;
         if (g !== w) begin n_err++; $display("FAIL csr[%0d] got mode/ovr/prio2=%h want=%h", i, g, w); end
      end
      n_vec++;
      if (thread_priority_o[1] !== 8'h80 || thread_enabled_o !== 4'b0111) begin
         n_err++; $display("FAIL csr_side_effect got prio1=%h en=%b want=80/0111", thread_priority_o[1], thread_enabled_o);
      end
   endtask

   task automatic test_store_wake();
      row_t rows[$];
      rows.push_back(mw(2'd1, 2'd1, 16'd0, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(st(2'd1, 40'h00_8000_0048, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(st(2'd1, 40'h00_8000_0044, e(0, 4'b0111, 4'b0, 4'b0010)));
      rows.push_back(idle(2'd1, e(1, 4'b0111, 0, 0)));
      foreach (rows[i]) begin
         drive(rows[i]); @(posedge clk_i); #1;
         got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
         want = sb.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL store_wake[%0d] got=%b want=%b", i, got, want); end
      end
   endtask

   task automatic test_timeout();
      row_t rows[$];
      rows.push_back(mw(2'd1, 2'd1, 16'd3, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0, 4'b0010)));
      rows.push_back(idle(2'd1, e(1, 4'b0111, 0, 0)));
      // store hit and expiry coincide: one wake only
      rows.push_back(mw(2'd1, 2'd1, 16'd2, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(st(2'd1, A, e(0, 4'b0111, 4'b0, 4'b0010)));
      rows.push_back(idle(2'd1, e(1, 4'b0111, 0, 0)));
      foreach (rows[i]) begin
         drive(rows[i]); @(posedge clk_i); #1;
         got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
         want = sb.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL timeout[%0d] got=%b want=%b", i, got, want); end
      end
   endtask

   task automatic test_mismatch();
      row_t rows[$];
      rows.push_back(mw(2'd2, 2'd1, 16'd0, e(1, 4'b0111, 0, 0)));
      rows.push_back(mk(1, 2'd1, 2'd1, 16'd0, 1, A, 0, 2'd0, 64'd0, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(st(2'd1, A, e(0, 4'b0111, 4'b0, 4'b0010)));
      rows.push_back(idle(2'd1, e(1, 4'b0111, 0, 0)));
      rows.push_back(mw(2'd3, 2'd3, 16'd0, e(0, 4'b0111, 0, 0)));
      rows.push_back(idle(2'd1, e(1, 4'b0111, 0, 0)));
      foreach (rows[i]) begin
         drive(rows[i]); @(posedge clk_i); #1;
         got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
         want = sb.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL mismatch[%0d] got=%b want=%b", i, got, want); end
      end
   endtask

   task automatic test_disable_prio();
      row_t rows[$];
      rows.push_back(mw(2'd1, 2'd1, 16'd0, e(0, 4'b0111, 4'b0010, 0)));
      rows.push_back(mk(0, 2'd0, 2'd1, 16'd0, 1, A, 1, 2'd0, 64'h5, e(0, 4'b0101, 0, 0)));
      rows.push_back(idle(2'd1, e(0, 4'b0101, 0, 0)));
      foreach (rows[i]) begin
         drive(rows[i]); @(posedge clk_i); #1;
         got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
         want = sb.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL disable_prio[%0d] got=%b want=%b", i, got, want); end
      end
   endtask

   task automatic test_reset_mid_wait();
      row_t rows[$];
      rows.push_back(mw(2'd2, 2'd2, 16'd5, e(0, 4'b0101, 4'b0100, 0)));
      rows.push_back(idle(2'd2, e(0, 4'b0101, 4'b0100, 0)));
      rows.push_back(idle(2'd2, e(0, 4'b0001, 0, 0)));
      for (int k = 0; k < 6; k++) rows.push_back(idle(2'd2, e(0, 4'b0001, 0, 0)));
      foreach (rows[i]) begin
         drive(rows[i]);
         reset_i = (i == 2) ? 1'b0 : 1'b1;
         @(posedge clk_i); #1;
         got = {mwait_ready_o, thread_enabled_o, thread_blocked_o, wake_mask_o};
         want = sb.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL reset_mid_wait[%0d] got=%b want=%b", i, got, want); end
         if (i == 2) begin
            n_vec++;
            if ({scheduler_mode_o, scheduler_override_tid_o, thread_priority_o[2]} !== {8'h00, 2'd0, 8'h80}) begin
               n_err++;
               $display("FAIL reset_mid_wait_csr got mode=%h ovr=%h prio2=%h want 00/0/80",
                        scheduler_mode_o, scheduler_override_tid_o, thread_priority_o[2]);
            end
         end
      end
      reset_i = 1'b1;
   endtask

   initial begin
      reset_i = 1'b0;
      test_reset();
      test_enable();
      test_csr();
      test_store_wake();
      test_timeout();
      test_mismatch();
      test_disable_prio();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
